serial_alu_sequencer: RTL and testbench

- Sequencer for the team's bit-serial ALU, which takes one bit of A, one of B and an opcode per clock, LSB first.
- Accepts a parallel request (op, a, b), clears the ALU carry state, then shifts the operands out one bit per cycle.
- Collects the serial result bits into a parallel WIDTH+1-bit result and signals completion with a one-cycle done pulse.
- Sits between the parallel host logic and the serial ALU, which is instantiated alongside this block, not inside it.

---
 rtl/serial_alu_pkg.sv | 28 ++
 rtl/serial_alu_capture.sv | 66 ++++++
 rtl/serial_alu_sequencer.sv | 136 +++++++++++++
 tb/tb_serial_alu_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_pkg
//  Description : Shared opcodes, defaults and FSM state type for the serial
//                ALU sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
package serial_alu_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_OPW   = 5;

    localparam logic [DEF_OPW-1:0] OP_ADD = 5'd0;
    localparam logic [DEF_OPW-1:0] OP_SUB = 5'd1;
    localparam logic [DEF_OPW-1:0] OP_AND = 5'd2;
    localparam logic [DEF_OPW-1:0] OP_OR  = 5'd3;
    localparam logic [DEF_OPW-1:0] OP_XOR = 5'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_alu_capture.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_capture
//  Description : Delays the shift-valid/bit-index pair by ALU_LAT cycles and
//                writes the returning ALU result bit into the parallel result.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_alu_capture #(
    parameter int WIDTH   = 8,
    parameter int ALU_LAT = 1,
    parameter int IW      = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_valid,
    input  logic [IW-1:0] i_idx,
    input  logic          i_res_bit,
    output logic [WIDTH:0] o_result
);

    logic          w_cap_valid;
    logic [IW-1:0] w_cap_idx;
    logic [WIDTH:0] r_result;

    generate
        if (ALU_LAT == 0) begin : g_lat_zero
            assign w_cap_valid = i_valid;
            assign w_cap_idx   = i_idx;
        end else begin : g_lat_pipe
            logic [ALU_LAT-1:0] r_vld;
            logic [IW-1:0]      r_idx [ALU_LAT];

            always_ff @(posedge clk) begin
                if (rst || i_clear) begin
                    r_vld <= '0;
                    for (int i = 0; i < ALU_LAT; i++) begin
                        r_idx[i] <= '0;
                    end
                end else begin
                    r_vld[0] <= i_valid;
                    r_idx[0] <= i_idx;
                    for (int i = 1; i < ALU_LAT; i++) begin
                        r_vld[i] <= r_vld[i-1];
                        r_idx[i] <= r_idx[i-1];
                    end
                end
            end

            assign w_cap_valid = r_vld[ALU_LAT-1];
            assign w_cap_idx   = r_idx[ALU_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_result <= '0;
        end else if (w_cap_valid) begin
            r_result[w_cap_idx] <= i_res_bit;
        end
    end

    assign o_result = r_result;

endmodule
`default_nettype wire

// File: rtl/serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : serial_alu_sequencer
//  Description : Feeds a parallel (op, a, b) request LSB-first into an external
//                bit-serial ALU and gathers its WIDTH+1-bit serial result.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_alu_sequencer
    import serial_alu_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int OPW     = DEF_OPW,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result,
    output logic             alu_clr,
    output logic             alu_en,
    output logic [OPW-1:0]   alu_op,
    output logic             alu_a_bit,
    output logic             alu_b_bit,
    input  logic             alu_res_bit
);

    localparam int             CW           = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  c_last       = CW'(WIDTH);
    localparam logic [1:0]     c_drain_last = 2'((ALU_LAT > 0) ? ALU_LAT - 1 : 0);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [OPW-1:0]   r_op;
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_drain;
    logic             w_accept;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_clr   = 1'b0;
        alu_en    = 1'b0;
        alu_a_bit = 1'b0;
        alu_b_bit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_CLEAR;
            end
            ST_CLEAR: begin
                busy    = 1'b1;
                alu_clr = 1'b1;
                w_next  = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy      = 1'b1;
                alu_en    = 1'b1;
                // Registers are zero-filled, so the pad cycle naturally drives 0.
                alu_a_bit = r_a_sh[0];
                alu_b_bit = r_b_sh[0];
                if (r_cnt == c_last) w_next = (ALU_LAT > 0) ? ST_DRAIN : ST_DONE;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (r_drain == c_drain_last) w_next = ST_DONE;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = start ? ST_CLEAR : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
            r_drain <= '0;
        end else begin
            if (w_accept) begin
                r_a_sh <= a;
                r_b_sh <= b;
                r_op   <= op;
            end
            case (r_state)
                ST_CLEAR: r_cnt <= '0;
                ST_SHIFT: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_drain <= '0;
                    if (r_cnt != c_last) r_cnt <= r_cnt + 1'b1;
                end
                ST_DRAIN: r_drain <= r_drain + 1'b1;
                default: ;
            endcase
        end
    end

    assign alu_op = r_op;

    serial_alu_capture #(
        .WIDTH   (WIDTH),
        .ALU_LAT (ALU_LAT),
        .IW      (CW)
    ) u_capture (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_accept),
        .i_valid   (r_state == ST_SHIFT),
        .i_idx     (r_cnt),
        .i_res_bit (alu_res_bit),
        .o_result  (result)
    );

endmodule
`default_nettype wire

// File: tb/tb_serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_alu_sequencer
//  Description : Directed scoreboard bench with a behavioural serial ALU per
//                sequencer instance (ALU_LAT = 1, 0 and 3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_alu_sequencer;
    import serial_alu_pkg::*;

    localparam int W  = 8;
    localparam int OW = 5;

    typedef struct {
        logic [W:0]    res;
        logic [OW-1:0] op;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [2:0]    start_v;
    logic [OW-1:0] op;
    logic [W-1:0]  a, b;
    logic [2:0]    busy_v, done_v, clr_v, en_v, abit_v, bbit_v, rbit_v;
    logic [W:0]    res_v [3];
    logic [OW-1:0] aop_v [3];

    int   errors   = 0;
    int   checks   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    function automatic logic [1:0] alu_f(input logic [OW-1:0] f_op, input logic fa, fb, fc);
        logic r, cn;
        r  = 1'b0;
        cn = 1'b0;
        case (f_op)
            OP_ADD: begin r = fa ^ fb ^ fc; cn = (fa & fb) | (fc & (fa ^ fb)); end
            OP_SUB: begin r = fa ^ fb ^ fc; cn = (~fa & fb) | (~(fa ^ fb) & fc); end
            OP_AND: r = fa & fb;
            OP_OR:  r = fa | fb;
            OP_XOR: r = fa ^ fb;
            default: r = 1'b0;
        endcase
        return {cn, r};
    endfunction

    function automatic logic [W:0] ref_f(input logic [OW-1:0] f_op, input logic [W-1:0] fa, fb);
        case (f_op)
            OP_ADD:  return {1'b0, fa} + {1'b0, fb};
            OP_SUB:  return {1'b0, fa} - {1'b0, fb};
            OP_AND:  return {1'b0, fa & fb};
            OP_OR:   return {1'b0, fa | fb};
            OP_XOR:  return {1'b0, fa ^ fb};
            default: return '0;
        endcase
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
            logic       carry = 1'b0;
            logic [3:0] pipe_q = '0;
            logic [1:0] f;
            logic [4:0] pipe;

            always_comb f = alu_f(aop_v[g], abit_v[g], bbit_v[g], carry);
            assign pipe = {pipe_q, f[0]};

            always @(posedge clk) begin
                if (clr_v[g])     carry <= 1'b0;
                else if (en_v[g]) carry <= f[1];
                pipe_q <= pipe[3:0];
            end

            assign rbit_v[g] = pipe[LAT];

            serial_alu_sequencer #(.WIDTH(W), .OPW(OW), .ALU_LAT(LAT)) u_dut (
                .clk         (clk),
                .rst         (rst),
                .start       (start_v[g]),
                .op          (op),
                .a           (a),
                .b           (b),
                .busy        (busy_v[g]),
                .done        (done_v[g]),
                .result      (res_v[g]),
                .alu_clr     (clr_v[g]),
                .alu_en      (en_v[g]),
                .alu_op      (aop_v[g]),
                .alu_a_bit   (abit_v[g]),
                .alu_b_bit   (bbit_v[g]),
                .alu_res_bit (rbit_v[g])
            );
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int idx, output int n);
        n = 0;
        while (done_v[idx] !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("done_seen", done_v[idx], 1);
    endtask

    task automatic drive(input logic [OW-1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op = o;
        a  = x;
        b  = y;
        sb.push_back('{ref_f(o, x, y), o});
    endtask

    // Scoreboard: every done pulse of the main instance retires one request.
    always @(negedge clk) begin
        if (done_v[0] === 1'b1) begin
            exp_t e;
            done_cnt++;
            chk("sb_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_result", res_v[0], e.res);
                chk("sb_alu_op", aop_v[0], e.op);
            end
        end
    end

    initial begin
        int n, n1, n2, bad, d0;
        logic [OW-1:0] t_op [4];
        logic [W-1:0]  t_a  [4];
        logic [W-1:0]  t_b  [4];
        logic ea, eb;

        rst = 1'b1; start_v = '0; op = '0; a = '0; b = '0;
        tick(); tick();
        chk("rst_busy", busy_v[0], 0);
        chk("rst_done", done_v[0], 0);
        chk("rst_result", res_v[0], 0);
        chk("rst_alu_op", aop_v[0], 0);
        chk("rst_clr_en", {clr_v[0], en_v[0], abit_v[0], bbit_v[0]}, 0);
        rst = 1'b0;
        tick();

        // ADD 0xFF + 0x01 with cycle-accurate control checks
        drive(OP_ADD, 8'hFF, 8'h01);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        chk("add_clr_c0", clr_v[0], 1);
        chk("add_busy_c0", busy_v[0], 1);
        chk("add_en_c0", en_v[0], 0);
        bad = 0;
        for (int k = 0; k <= W; k++) begin
            tick();
            ea = (k < W) ? a[k] : 1'b0;
            eb = (k < W) ? b[k] : 1'b0;
            if (en_v[0] !== 1'b1 || clr_v[0] !== 1'b0 || abit_v[0] !== ea || bbit_v[0] !== eb) bad++;
        end
        chk("add_shift_cycles", bad, 0);
        tick();
        chk("add_drain_en", en_v[0], 0);
        chk("add_drain_busy", busy_v[0], 1);
        chk("add_drain_done", done_v[0], 0);
        tick();
        chk("add_done_c11", done_v[0], 1);
        chk("add_busy_in_done", busy_v[0], 0);
        chk("add_result", res_v[0], 9'h100);
        tick();
        chk("add_done_pulse", done_v[0], 0);
        chk("add_result_hold", res_v[0], 9'h100);

        // SUB 0x05 - 0x07; inputs scrambled while busy, op must stay latched
        drive(OP_SUB, 8'h05, 8'h07);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        op = OP_XOR; a = 8'hAA; b = 8'h55;
        bad = 0;
        n = 0;
        while (done_v[0] !== 1'b1 && n < 40) begin
            if (aop_v[0] !== OP_SUB) bad++;
            tick();
            n++;
        end
        if (aop_v[0] !== OP_SUB) bad++;
        chk("sub_op_stable", bad, 0);
        chk("sub_latency", n, 11);
        chk("sub_borrow_bit", res_v[0][W], 1);
        tick();

        // ADD 0x12 + 0x34 with start pulses while busy
        drive(OP_ADD, 8'h12, 8'h34);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        d0 = done_cnt;
        for (int c = 1; c <= 15; c++) begin
            tick();
            start_v[0] = (c == 3 || c == 7);
            a = 8'hC3; b = 8'h3C;
        end
        start_v[0] = 1'b0;
        chk("busy_start_single_done", done_cnt - d0, 1);
        chk("busy_start_result", res_v[0], 9'h046);
        chk("busy_start_idle", busy_v[0], 0);

        // Back-to-back with start held high
        t_op[0] = OP_ADD; t_a[0] = 8'h80; t_b[0] = 8'h80;
        t_op[1] = OP_SUB; t_a[1] = 8'h10; t_b[1] = 8'h20;
        t_op[2] = OP_XOR; t_a[2] = 8'h5A; t_b[2] = 8'hFF;
        t_op[3] = OP_OR;  t_a[3] = 8'h0F; t_b[3] = 8'hF0;
        drive(t_op[0], t_a[0], t_b[0]);
        start_v[0] = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(t_op[i+1], t_a[i+1], t_b[i+1]);
            else       start_v[0] = 1'b0;
            wait_done(0, n);
            chk("b2b_latency", n, 11);
            if (i < 2) begin
                tick();
                chk("b2b_no_idle", clr_v[0], 1);
            end
        end
        tick();
        chk("b2b_final_idle", busy_v[0], 0);

        // Reset in the middle of SHIFT, then a clean operation
        op = OP_ADD; a = 8'hFF; b = 8'hFF;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        repeat (5) tick();
        chk("pre_rst_shift", en_v[0], 1);
        rst = 1'b1;
        tick();
        chk("mid_rst_ctrl", {busy_v[0], done_v[0], clr_v[0], en_v[0], abit_v[0], bbit_v[0]}, 0);
        chk("mid_rst_result", res_v[0], 0);
        chk("mid_rst_alu_op", aop_v[0], 0);
        chk("mid_rst_cnt", g_dut[0].u_dut.r_cnt, 0);
        chk("mid_rst_state", g_dut[0].u_dut.r_state, ST_IDLE);
        rst = 1'b0;
        tick();
        drive(OP_ADD, 8'h0F, 8'h0F);
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        wait_done(0, n);
        chk("post_rst_latency", n, 11);
        chk("post_rst_result", res_v[0], 9'h01E);
        tick();

        // Latency sweep: ALU_LAT = 0 and 3
        op = OP_AND; a = 8'hF0; b = 8'h3C;
        start_v[2:1] = 2'b11;
        tick();
        start_v[2:1] = 2'b00;
        n1 = -1;
        n2 = -1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (done_v[1] === 1'b1 && n1 < 0) n1 = c;
            if (done_v[2] === 1'b1 && n2 < 0) n2 = c;
        end
        chk("lat0_done_cycle", n1, 10);
        chk("lat3_done_cycle", n2, 13);
        chk("lat0_result", res_v[1], 9'h030);
        chk("lat3_result", res_v[2], 9'h030);

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
